serial_code_lock: RTL and testbench

Parametrised serial code detector (code lock), successor to the fixed 4-bit coder. It collects CODE_W-bit frames from a serial input and compares each frame with a programmable stored code. It pulses on match or mismatch, counts failed attempts, and enters a timed lockout after MAX_TRIES consecutive failures. It sits between a serial keypad/front-end and the unlock/alarm logic.

---
 rtl/serial_code_lock.sv | 136 +++++++++++++
 tb/tb_serial_code_lock.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_code_lock.sv
// -----------------------------------------------------------------------------
// serial_code_lock
//
// Serial code detector. CODE_W-bit frames arrive MSB first on `in`, one bit per
// cycle where in_valid is high. Each complete frame is compared with a
// programmable code register. A match pulses `out`. A mismatch pulses `fail`
// and uses up one attempt. When the last attempt fails, the block enters a
// lockout of LOCK_CYCLES cycles. During lockout all input is ignored.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   in_valid    in   qualifies `in`; one bit accepted per cycle when high
//   in          in   serial code bit, MSB of frame first
//   load_en     in   single-cycle strobe: write load_code, abort partial frame
//   load_code   in   [CODE_W] new code value
//   out         out  match pulse, 1 cycle
//   fail        out  mismatch pulse, 1 cycle
//   locked_out  out  high while in lockout
//   tries_left  out  [$clog2(MAX_TRIES+1)] remaining attempts
// -----------------------------------------------------------------------------
module serial_code_lock #(
    parameter int                CODE_W       = 4,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = 4'b1011,
    parameter int                MAX_TRIES    = 3,
    parameter int                LOCK_CYCLES  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in,
    input  logic                           load_en,
    input  logic [CODE_W-1:0]              load_code,
    output logic                           out,
    output logic                           fail,
    output logic                           locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

    localparam int CNT_W  = $clog2(CODE_W);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(CODE_W - 1);
    localparam logic [TRY_W-1:0]  TRIES_FULL = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0]  ONE_TRY    = TRY_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] LOCKOUT = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    // Only the CODE_W-1 bits already received are stored. The final bit of a
    // frame is compared straight from `in`, so it is never registered.
    logic [CODE_W-2:0] shift;
    logic [CODE_W-1:0] code;
    logic [LOCK_W-1:0] lock_cnt;

    logic [CODE_W-1:0] frame_next;
    logic              frame_match;

    assign frame_next  = {shift, in};
    assign frame_match = (frame_next == code);

    // The state register is itself a flop, so this output is still registered.
    assign locked_out = (state == LOCKOUT);

    // NOTE: Sequential state uses non-blocking assignments only. Then every
    // flop samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            bit_cnt    <= '0;
            shift      <= '0;
            // NOTE: The code register is a normal reset flop, not a memory.
            // Reset always restores DEFAULT_CODE, and a loaded code is lost.
            code       <= DEFAULT_CODE;
            out        <= 1'b0;
            fail       <= 1'b0;
            tries_left <= TRIES_FULL;
            lock_cnt   <= '0;
        end else begin
            // Pulses default low, so each one lasts a single cycle.
            out  <= 1'b0;
            fail <= 1'b0;

            case (state)
                COLLECT: begin
                    if (load_en) begin
                        // A load beats a bit arriving in the same cycle.
                        // The partial frame is dropped, and no compare happens.
                        code    <= load_code;
                        bit_cnt <= '0;
                        shift   <= '0;
                    end else if (in_valid) begin
                        shift <= frame_next[CODE_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (frame_match) begin
                                out        <= 1'b1;
                                tries_left <= TRIES_FULL;
                            end else begin
                                fail <= 1'b1;
                                if (tries_left > ONE_TRY) begin
                                    tries_left <= tries_left - 1'b1;
                                end else begin
                                    // Last attempt used: lock out.
                                    // The lockout counts this cycle, so the
                                    // counter starts at LOCK_CYCLES-1.
                                    tries_left <= '0;
                                    state      <= LOCKOUT;
                                    lock_cnt   <= LOCK_LOAD;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    // LOCKOUT: inputs are ignored until the counter runs out.
                    if (lock_cnt == '0) begin
                        state      <= COLLECT;
                        tries_left <= TRIES_FULL;
                        bit_cnt    <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_code_lock.sv
// -----------------------------------------------------------------------------
// tb_serial_code_lock
//
// Drives two instances of serial_code_lock:
//   index 0: CODE_W=4, code 1011, MAX_TRIES=3, LOCK_CYCLES=16
//   index 1: CODE_W=8, code A5,   MAX_TRIES=1, LOCK_CYCLES=5
// A frame-level reference model predicts out, fail, locked_out and tries_left
// for every cycle. Directed steps also check constant expectations.
// -----------------------------------------------------------------------------
module tb_serial_code_lock;

    logic       clk;
    logic       rst;
    logic [1:0] iv;
    logic [1:0] ibit;
    logic [1:0] ld;
    logic [7:0] lc [2];
    logic [1:0] o_out;
    logic [1:0] o_fail;
    logic [1:0] o_lock;
    logic [1:0] a_tries;
    logic [0:0] b_tries;

    int n_assert = 0;
    int n_fail   = 0;
    int lock_seen [2];

    // Reference model: frame value/length, attempt count, remaining lockout.
    int m_cw   [2] = '{4, 8};
    int m_max  [2] = '{3, 1};
    int m_lock [2] = '{16, 5};
    int m_def  [2] = '{'hB, 'hA5};
    int m_code [2];
    int m_val  [2];
    int m_len  [2];
    int m_tries[2];
    int m_rem  [2];
    bit m_out  [2];
    bit m_fail [2];

    serial_code_lock #(
        .CODE_W(4), .DEFAULT_CODE(4'b1011), .MAX_TRIES(3), .LOCK_CYCLES(16)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[0]),
        .in         (ibit[0]),
        .load_en    (ld[0]),
        .load_code  (lc[0][3:0]),
        .out        (o_out[0]),
        .fail       (o_fail[0]),
        .locked_out (o_lock[0]),
        .tries_left (a_tries)
    );

    serial_code_lock #(
        .CODE_W(8), .DEFAULT_CODE(8'hA5), .MAX_TRIES(1), .LOCK_CYCLES(5)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[1]),
        .in         (ibit[1]),
        .load_en    (ld[1]),
        .load_code  (lc[1]),
        .out        (o_out[1]),
        .fail       (o_fail[1]),
        .locked_out (o_lock[1]),
        .tries_left (b_tries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_code[k]  = m_def[k];
            m_val[k]   = 0;
            m_len[k]   = 0;
            m_tries[k] = m_max[k];
            m_rem[k]   = 0;
            m_out[k]   = 1'b0;
            m_fail[k]  = 1'b0;
        end
    endfunction

    // Advance model k by one clock, using the inputs sampled at that edge.
    function automatic void model_step(input int k);
        m_out[k]  = 1'b0;
        m_fail[k] = 1'b0;
        if (m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
                m_tries[k] = m_max[k];
                m_val[k]   = 0;
                m_len[k]   = 0;
            end
        end else if (ld[k]) begin
            m_code[k] = int'(lc[k]) & ((1 << m_cw[k]) - 1);
            m_val[k]  = 0;
            m_len[k]  = 0;
        end else if (iv[k]) begin
            m_val[k] = m_val[k] * 2 + int'(ibit[k]);
            m_len[k]++;
            if (m_len[k] == m_cw[k]) begin
                if (m_val[k] == m_code[k]) begin
                    m_out[k]   = 1'b1;
                    m_tries[k] = m_max[k];
                end else begin
                    m_fail[k] = 1'b1;
                    m_tries[k]--;
                    if (m_tries[k] == 0) m_rem[k] = m_lock[k];
                end
                m_val[k] = 0;
                m_len[k] = 0;
            end
        end
    endfunction

    // One clock: step the models at the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out[%0d]", k),    32'(o_out[k]),  32'(m_out[k]));
            check($sformatf("fail[%0d]", k),   32'(o_fail[k]), 32'(m_fail[k]));
            check($sformatf("locked[%0d]", k), 32'(o_lock[k]), 32'(m_rem[k] > 0));
            if (o_lock[k]) lock_seen[k]++;
        end
        check("tries[0]", 32'(a_tries), 32'(m_tries[0]));
        check("tries[1]", 32'(b_tries), 32'(m_tries[1]));
    endtask

    // Send one frame MSB first, with up to gap_max idle cycles before each bit.
    task automatic send_frame(input int k, input logic [7:0] v, input int gap_max);
        for (int i = m_cw[k] - 1; i >= 0; i--) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                iv[k] = 1'b0;
                repeat (g) tick();
            end
            iv[k]   = 1'b1;
            ibit[k] = v[i];
            tick();
        end
        iv[k] = 1'b0;
    endtask

    task automatic load_pulse(input int k, input logic [7:0] v);
        ld[k]   = 1'b1;
        lc[k]   = v;
        iv[k]   = 1'($urandom_range(0, 1));
        ibit[k] = 1'($urandom_range(0, 1));
        tick();
        ld[k] = 1'b0;
        iv[k] = 1'b0;
    endtask

    task automatic wait_unlock(input int k);
        for (int i = 0; i < 40 && o_lock[k]; i++) tick();
        check($sformatf("unlock_timeout[%0d]", k), 32'(o_lock[k]), 32'd0);
    endtask

    task automatic random_frames(input int k, input int n);
        for (int f = 0; f < n; f++) begin
            logic [7:0] v;
            if ($urandom_range(0, 19) == 0) load_pulse(k, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) v = 8'(m_code[k]);
            else                           v = 8'($urandom_range(0, 255));
            send_frame(k, v, 2);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iv = '0; ibit = '0; ld = '0; lc[0] = '0; lc[1] = '0;
        lock_seen[0] = 0; lock_seen[1] = 0;
        model_reset();
        rst = 1'b1;
        #12;
        check("rst_out_a",    32'(o_out[0]),  32'd0);
        check("rst_fail_a",   32'(o_fail[0]), 32'd0);
        check("rst_locked_a", 32'(o_lock[0]), 32'd0);
        check("rst_tries_a",  32'(a_tries),   32'd3);
        check("rst_tries_b",  32'(b_tries),   32'd1);
        rst = 1'b0;

        // 1: default code matches
        send_frame(0, 8'hB, 0);
        check("t1_out",   32'(o_out[0]),  32'd1);
        check("t1_fail",  32'(o_fail[0]), 32'd0);
        check("t1_tries", 32'(a_tries),   32'd3);
        tick();
        check("t1_out_drop", 32'(o_out[0]), 32'd0);

        // 2: one miss, then a hit restores attempts
        send_frame(0, 8'hA, 0);
        check("t2_fail",  32'(o_fail[0]), 32'd1);
        check("t2_tries", 32'(a_tries),   32'd2);
        send_frame(0, 8'hB, 0);
        check("t2_out",   32'(o_out[0]),  32'd1);
        check("t2_tries_restore", 32'(a_tries), 32'd3);

        // 3: three misses -> 16-cycle lockout, correct code ignored meanwhile
        lock_seen[0] = 0;
        send_frame(0, 8'hA, 0);
        send_frame(0, 8'hA, 0);
        send_frame(0, 8'hA, 0);
        check("t3_fail",   32'(o_fail[0]), 32'd1);
        check("t3_locked", 32'(o_lock[0]), 32'd1);
        check("t3_tries0", 32'(a_tries),   32'd0);
        send_frame(0, 8'hB, 0);
        check("t3_lock_out",  32'(o_out[0]),  32'd0);
        check("t3_lock_fail", 32'(o_fail[0]), 32'd0);
        wait_unlock(0);
        check("t3_lock_len", 32'(lock_seen[0]), 32'd16);
        check("t3_tries",    32'(a_tries),      32'd3);
        send_frame(0, 8'hB, 0);
        check("t3_out_after", 32'(o_out[0]), 32'd1);

        // 4: load aborts a partial frame, new code applies
        iv[0] = 1'b1; ibit[0] = 1'b1; tick();
        ibit[0] = 1'b0; tick();
        iv[0] = 1'b0; ld[0] = 1'b1; lc[0] = 8'h06; tick();
        ld[0] = 1'b0;
        send_frame(0, 8'h6, 0);
        check("t4_out_new", 32'(o_out[0]), 32'd1);
        send_frame(0, 8'hB, 0);
        check("t4_fail_old", 32'(o_fail[0]), 32'd1);
        check("t4_tries",    32'(a_tries),   32'd2);

        // 5: load together with the 4th bit, no compare
        iv[0] = 1'b1;
        ibit[0] = 1'b0; tick();
        ibit[0] = 1'b1; tick();
        ibit[0] = 1'b1; tick();
        ibit[0] = 1'b0; ld[0] = 1'b1; lc[0] = 8'h06; tick();
        check("t5_no_out",  32'(o_out[0]),  32'd0);
        check("t5_no_fail", 32'(o_fail[0]), 32'd0);
        iv[0] = 1'b0; ld[0] = 1'b0;
        send_frame(0, 8'h6, 0);
        check("t5_out_clean", 32'(o_out[0]), 32'd1);
        // Reset during lockout
        send_frame(0, 8'hF, 0);
        send_frame(0, 8'hF, 0);
        send_frame(0, 8'hF, 0);
        check("t5_locked", 32'(o_lock[0]), 32'd1);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("t5_rst_locked", 32'(o_lock[0]), 32'd0);
        check("t5_rst_tries",  32'(a_tries),   32'd3);
        rst = 1'b0;
        model_reset();
        send_frame(0, 8'hB, 0);
        check("t5_default_code", 32'(o_out[0]), 32'd1);

        // 6: wide instance, single attempt, 5-cycle lockout
        send_frame(1, 8'hA5, 2);
        check("t6_out",   32'(o_out[1]), 32'd1);
        check("t6_tries", 32'(b_tries),  32'd1);
        lock_seen[1] = 0;
        send_frame(1, 8'hA4, 0);
        check("t6_fail",   32'(o_fail[1]), 32'd1);
        check("t6_locked", 32'(o_lock[1]), 32'd1);
        wait_unlock(1);
        check("t6_lock_len", 32'(lock_seen[1]), 32'd5);
        check("t6_tries_back", 32'(b_tries), 32'd1);

        // Random frames against the model, checked every cycle
        random_frames(1, 1000);
        random_frames(0, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
